// File: rtl/bound_up_down_ctrl_if.sv
// Port bundle for the line-buffer replay controller: sync inputs, buffer strobes and output timing.
interface bound_up_down_ctrl_if;
  logic        din_vsync;
  logic        din_hsync;
  logic        buf_wr_en;
  logic [13:0] buf_wr_addr;
  logic        buf_rd_en;
  logic [13:0] buf_rd_addr;
  logic        dout_sel;
  logic        dout_hsync;
  logic        dout_vsync;
  logic        err;

  modport slave (
    input  din_vsync, din_hsync,
    output buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr,
           dout_sel, dout_hsync, dout_vsync, err
  );

  modport master (
    output din_vsync, din_hsync,
    input  buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr,
           dout_sel, dout_hsync, dout_vsync, err
  );
endinterface

// File: rtl/bound_up_down_ctrl.sv
// Top/bottom border controller: replays the first and last image rows P times from a line buffer
// so a KSZ x KSZ window sees replicated edge rows.
module bound_up_down_ctrl #(
  parameter int KSZ  = 'd3,
  parameter int DW   = 'd8,
  parameter int IW   = 'd640,
  parameter int IH   = 'd480,
  parameter int HBLK = 'd16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bound_up_down_ctrl_if.slave   bus
);

  localparam int          P         = (KSZ - 1) / 2;
  localparam logic [13:0] IW_W      = 14'(IW);
  localparam logic [15:0] IW_LAST   = 16'(IW - 1);
  localparam logic [15:0] HBLK_LAST = 16'(HBLK - 1);
  localparam logic [15:0] ROW_LAST  = 16'(IH - 1);
  localparam logic [2:0]  REP_LAST  = 3'(P - 1);

  if ((KSZ != 3 && KSZ != 5 && KSZ != 7) || DW < 1 || IW < 1 || IW > 16383 || HBLK < 1)
  begin : g_param_err
    $error("bound_up_down_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, GAP, READ} state_t;

  state_t      state_reg, state_next;
  logic        vs_d1, hs_d1;
  logic [13:0] wr_cnt_reg, wr_cnt_next;
  logic [15:0] row_cnt_reg;
  logic [15:0] ph_cnt_reg, ph_cnt_next;
  logic [2:0]  rep_cnt_reg, rep_cnt_next;
  logic        err_reg, dout_hsync_reg, dout_sel_reg;

  logic vs_rise, hs_rise, hs_fall, trigger, abort, rd_en;

  assign vs_rise = bus.din_vsync & ~vs_d1;
  assign hs_rise = bus.din_hsync & ~hs_d1;
  assign hs_fall = ~bus.din_hsync & hs_d1;
  // row_cnt still holds the index of the row that is ending on this falling edge
  assign trigger = hs_fall & ((row_cnt_reg == 16'd0) | (row_cnt_reg == ROW_LAST));
  assign abort   = (state_reg != IDLE) & (hs_rise | vs_rise);
  assign rd_en   = (state_reg == READ);

  assign wr_cnt_next = !bus.din_hsync     ? 14'd0 :
                       (wr_cnt_reg == IW_W) ? wr_cnt_reg : wr_cnt_reg + 14'd1;

  always_comb begin
    state_next   = state_reg;
    ph_cnt_next  = ph_cnt_reg;
    rep_cnt_next = rep_cnt_reg;
    if (abort) begin
      state_next  = IDLE;
      ph_cnt_next = 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            state_next   = GAP;
            ph_cnt_next  = 16'd0;
            rep_cnt_next = 3'd0;
          end
        end
        GAP: begin
          if (ph_cnt_reg == HBLK_LAST) begin
            state_next  = READ;
            ph_cnt_next = 16'd0;
          end else begin
            ph_cnt_next = ph_cnt_reg + 16'd1;
          end
        end
        READ: begin
          if (ph_cnt_reg == IW_LAST) begin
            ph_cnt_next = 16'd0;
            if (rep_cnt_reg < REP_LAST) begin
              state_next   = GAP;
              rep_cnt_next = rep_cnt_reg + 3'd1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            ph_cnt_next = ph_cnt_reg + 16'd1;
          end
        end
        default: begin
          state_next  = IDLE;
          ph_cnt_next = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      vs_d1          <= 1'b0;
      hs_d1          <= 1'b0;
      wr_cnt_reg     <= 14'd0;
      row_cnt_reg    <= 16'd0;
      ph_cnt_reg     <= 16'd0;
      rep_cnt_reg    <= 3'd0;
      err_reg        <= 1'b0;
      dout_hsync_reg <= 1'b0;
      dout_sel_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vs_d1          <= bus.din_vsync;
      hs_d1          <= bus.din_hsync;
      wr_cnt_reg     <= wr_cnt_next;
      ph_cnt_reg     <= ph_cnt_next;
      rep_cnt_reg    <= rep_cnt_next;
      dout_hsync_reg <= bus.din_hsync | rd_en;
      dout_sel_reg   <= rd_en;
      if (vs_rise)
        row_cnt_reg <= 16'd0;
      else if (hs_fall)
        row_cnt_reg <= row_cnt_reg + 16'd1;
      // abort implies non-IDLE, so a vsync rise without abort is the IDLE-only clear
      if (abort)
        err_reg <= 1'b1;
      else if (vs_rise)
        err_reg <= 1'b0;
    end
  end

  // write side is combinational on the live sync so the strobe lines up with the live pixel
  assign bus.buf_wr_addr = bus.din_hsync ? wr_cnt_reg : 14'd0;
  assign bus.buf_wr_en   = rst_n & bus.din_hsync & (wr_cnt_reg < IW_W);
  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = rd_en ? ph_cnt_reg[13:0] : 14'd0;
  assign bus.dout_sel    = dout_sel_reg;
  assign bus.dout_hsync  = dout_hsync_reg;
  assign bus.dout_vsync  = vs_d1 | (state_reg != IDLE) | dout_hsync_reg;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_bound_up_down_ctrl.sv
// Checks KSZ=3 and KSZ=7 controllers side by side against a schedule-based reference model.
module tb_bound_up_down_ctrl;

  localparam int IW   = 8;
  localparam int IH   = 4;
  localparam int HBLK = 2;
  localparam int PER  = HBLK + IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic vs_r  = 1'b0;
  logic hs_r  = 1'b0;

  bound_up_down_ctrl_if bus3 ();
  bound_up_down_ctrl_if bus7 ();

  assign bus3.din_vsync = vs_r;
  assign bus3.din_hsync = hs_r;
  assign bus7.din_vsync = vs_r;
  assign bus7.din_hsync = hs_r;

  bound_up_down_ctrl #(.KSZ(3), .DW(8), .IW(IW), .IH(IH), .HBLK(HBLK)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );
  bound_up_down_ctrl #(.KSZ(7), .DW(8), .IW(IW), .IH(IH), .HBLK(HBLK)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .bus(bus7)
  );

  logic [1:0]  o_wr_en, o_rd_en, o_sel, o_dhs, o_dvs, o_err;
  logic [13:0] o_wr_addr [2];
  logic [13:0] o_rd_addr [2];

  assign o_wr_en[0] = bus3.buf_wr_en;   assign o_wr_en[1] = bus7.buf_wr_en;
  assign o_rd_en[0] = bus3.buf_rd_en;   assign o_rd_en[1] = bus7.buf_rd_en;
  assign o_sel[0]   = bus3.dout_sel;    assign o_sel[1]   = bus7.dout_sel;
  assign o_dhs[0]   = bus3.dout_hsync;  assign o_dhs[1]   = bus7.dout_hsync;
  assign o_dvs[0]   = bus3.dout_vsync;  assign o_dvs[1]   = bus7.dout_vsync;
  assign o_err[0]   = bus3.err;         assign o_err[1]   = bus7.err;
  assign o_wr_addr[0] = bus3.buf_wr_addr;  assign o_wr_addr[1] = bus7.buf_wr_addr;
  assign o_rd_addr[0] = bus3.buf_rd_addr;  assign o_rd_addr[1] = bus7.buf_rd_addr;

  int    n_cmp = 0;
  int    n_fail = 0;
  longint cyc = 0;

  // reference state: a replay job is a start cycle plus an (abortable) end cycle
  bit     m_job [2];
  longint m_t   [2];
  longint m_end [2];
  bit     m_pvs [2], m_phs [2], m_prd [2], m_err [2];
  int     m_run [2], m_row [2];

  int rd_seen [2], sel_seen [2], wr_seen [2], wr_max [2];

  function automatic int reps(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(string nm, int k, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s K%0d cyc=%0d got=%0d want=%0d", nm, (k == 0) ? 3 : 7, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit  busy, e_rd, e_dhs, e_dvs, e_wen, vsr, hsr, hsf;
    int  off, e_ra, e_wa;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk("rst_wr_en", k, o_wr_en[k], 0);
        chk("rst_wr_addr", k, o_wr_addr[k], 0);
        chk("rst_rd_en", k, o_rd_en[k], 0);
        chk("rst_rd_addr", k, o_rd_addr[k], 0);
        chk("rst_sel", k, o_sel[k], 0);
        chk("rst_dout_hsync", k, o_dhs[k], 0);
        chk("rst_dout_vsync", k, o_dvs[k], 0);
        chk("rst_err", k, o_err[k], 0);
        m_job[k] = 0; m_pvs[k] = 0; m_phs[k] = 0; m_prd[k] = 0;
        m_err[k] = 0; m_run[k] = 0; m_row[k] = 0;
      end else begin
        vsr  = vs_r & ~m_pvs[k];
        hsr  = hs_r & ~m_phs[k];
        hsf  = ~hs_r & m_phs[k];
        busy = m_job[k] && (cyc >= m_t[k] + 1) && (cyc <= m_end[k]);
        off  = busy ? int'((cyc - m_t[k] - 1) % PER) : 0;
        e_rd = busy && (off >= HBLK);
        e_ra = e_rd ? off - HBLK : 0;
        e_wa = hs_r ? ((m_run[k] < IW) ? m_run[k] : IW) : 0;
        e_wen = hs_r && (m_run[k] < IW);
        e_dhs = m_phs[k] | m_prd[k];
        e_dvs = m_pvs[k] | busy | e_dhs;

        chk("wr_en", k, o_wr_en[k], e_wen);
        chk("wr_addr", k, o_wr_addr[k], e_wa);
        chk("rd_en", k, o_rd_en[k], e_rd);
        chk("rd_addr", k, o_rd_addr[k], e_ra);
        chk("dout_sel", k, o_sel[k], m_prd[k]);
        chk("dout_hsync", k, o_dhs[k], e_dhs);
        chk("dout_vsync", k, o_dvs[k], e_dvs);
        chk("err", k, o_err[k], m_err[k]);

        if (busy && (hsr || vsr)) begin
          m_end[k] = cyc;
          m_err[k] = 1;
        end else if (vsr) begin
          m_err[k] = 0;
        end
        if (!busy && hsf && (m_row[k] == 0 || m_row[k] == IH - 1)) begin
          m_job[k] = 1;
          m_t[k]   = cyc;
          m_end[k] = cyc + longint'(reps(k) * PER);
        end
        if (vsr)      m_row[k] = 0;
        else if (hsf) m_row[k] = m_row[k] + 1;
        m_run[k] = hs_r ? m_run[k] + 1 : 0;
        m_prd[k] = e_rd;
        m_phs[k] = hs_r;
        m_pvs[k] = vs_r;
      end
      if (o_rd_en[k]) rd_seen[k]++;
      if (o_sel[k])   sel_seen[k]++;
      if (o_wr_en[k]) wr_seen[k]++;
      if (int'(o_wr_addr[k]) > wr_max[k]) wr_max[k] = int'(o_wr_addr[k]);
    end
    cyc++;
  end

  task automatic step(bit v, bit h, bit r);
    @(posedge clk);
    #1;
    rst_n = r;
    vs_r  = v;
    hs_r  = h;
  endtask

  task automatic idle(bit v, int n);
    repeat (n) step(v, 1'b0, 1'b1);
  endtask

  task automatic send_line(bit v, int len, int gap);
    $display("line: vs=%0b len=%0d gap=%0d start_cyc=%0d", v, len, gap, cyc);
    repeat (len) step(v, 1'b1, 1'b1);
    repeat (gap) step(v, 1'b0, 1'b1);
  endtask

  task automatic clr_obs();
    for (int k = 0; k < 2; k++) begin
      rd_seen[k] = 0; sel_seen[k] = 0; wr_seen[k] = 0; wr_max[k] = 0;
    end
  endtask

  bit vs_cur;

  initial begin
    clr_obs();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(1'b0, 3);

    // full 4-line frame, vsync drops one cycle after the last row ends
    clr_obs();
    idle(1'b1, 3);
    repeat (3) send_line(1'b1, 8, 40);
    send_line(1'b1, 8, 1);
    idle(1'b0, 50);
    chk("frame_rd_cnt", 0, rd_seen[0], 16);
    chk("frame_rd_cnt", 1, rd_seen[1], 48);
    chk("frame_sel_cnt", 0, sel_seen[0], 16);
    chk("frame_sel_cnt", 1, sel_seen[1], 48);
    chk("frame_err", 0, o_err[0], 0);

    // next line starts while row 0's replay is reading
    clr_obs();
    idle(1'b1, 2);
    send_line(1'b1, 8, 5);
    send_line(1'b1, 8, 40);
    idle(1'b0, 40);
    chk("abort_rd_cnt", 0, rd_seen[0], 3);
    chk("abort_rd_cnt", 1, rd_seen[1], 3);
    chk("abort_err", 0, o_err[0], 1);
    chk("abort_err", 1, o_err[1], 1);

    // over-long line: writes stop at IW, address saturates
    clr_obs();
    idle(1'b1, 2);
    send_line(1'b1, 10, 40);
    idle(1'b0, 40);
    chk("long_wr_cnt", 0, wr_seen[0], 8);
    chk("long_wr_max", 0, wr_max[0], 8);
    chk("long_err_clr", 0, o_err[0], 0);
    chk("long_rd_cnt", 1, rd_seen[1], 24);

    // reset pulse during the gap before a replay
    clr_obs();
    idle(1'b1, 2);
    send_line(1'b1, 8, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle(1'b1, 30);
    chk("rst_gap_rd_cnt", 0, rd_seen[0], 0);
    chk("rst_gap_rd_cnt", 1, rd_seen[1], 0);
    idle(1'b0, 5);
    clr_obs();
    idle(1'b1, 2);
    send_line(1'b1, 8, 40);
    idle(1'b0, 40);
    chk("post_rst_rd_cnt", 0, rd_seen[0], 8);
    chk("post_rst_rd_cnt", 1, rd_seen[1], 24);

    // randomized traffic: variable lines, gaps, vsync toggles and occasional resets
    vs_cur = 1'b0;
    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        $display("reset pulse at cyc=%0d", cyc);
        step(vs_cur, 1'b0, 1'b0);
        step(vs_cur, 1'b0, 1'b1);
      end else if (r < 4) begin
        vs_cur = ~vs_cur;
        idle(vs_cur, int'($urandom_range(1, 5)));
      end else begin
        send_line(vs_cur, int'($urandom_range(1, 11)), int'($urandom_range(1, 45)));
      end
    end
    idle(1'b0, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
